writeback_stage: RTL and testbench

//  Final stage of the 64-bit RV64I pipeline. Consumes the MEM->WB pipeline latch and retires one instruction per cycle.

---
 rtl/writeback_stage.sv | 159 +++++++++++++++
 tb/tb_writeback_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// RV64I writeback stage: load-response wait/align, 32x64 register file, redirects, INSTRET.
// Define WB_BYPASS_EN to make the decode read ports write-through for same-cycle writes.
module writeback_stage #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            WB_V,
  input  logic [31:0]     WB_IR,
  input  logic [XLEN-1:0] WB_NPC,
  input  logic [XLEN-1:0] WB_ALU_RESULT,
  input  logic [XLEN-1:0] WB_CSRFD,
  input  logic            WB_PC_MUX,
  input  logic            DMEM_RVALID,
  input  logic [XLEN-1:0] DMEM_RDATA,
  input  logic [4:0]      DE_SR1_ID,
  input  logic [4:0]      DE_SR2_ID,
  output logic [XLEN-1:0] DE_SR1_DATA,
  output logic [XLEN-1:0] DE_SR2_DATA,
  output logic            WB_STALL,
  output logic            REDIRECT_V,
  output logic [XLEN-1:0] REDIRECT_PC,
  output logic            LOAD_FAULT,
  output logic [XLEN-1:0] INSTRET
);
  localparam int unsigned CW = $clog2(LOAD_TIMEOUT + 1);

  typedef enum logic {RUN, LOAD_WAIT} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   regs_q [32];
  logic [XLEN-1:0]   regs_d [32];
  logic              redirect_v_q, redirect_v_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              load_fault_q, load_fault_d;
  logic [XLEN-1:0]   instret_q, instret_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic            is_load, at_timeout, fault_now, retire;
  logic            wen_op, wr_en;
  logic [XLEN-1:0] wr_data, load_data, lane;
  logic            unused_ir;

  assign opcode    = WB_IR[6:0];
  assign funct3    = WB_IR[14:12];
  assign rd        = WB_IR[11:7];
  assign unused_ir = ^WB_IR[31:15];

  assign is_load    = WB_V && (opcode == 7'b0000011);
  assign at_timeout = (state_q == LOAD_WAIT) && (cnt_q == CW'(LOAD_TIMEOUT));
  assign fault_now  = is_load && !DMEM_RVALID && at_timeout;
  assign WB_STALL   = is_load && !DMEM_RVALID && !at_timeout;
  assign retire     = WB_V && !WB_STALL;

  always_comb begin
    lane      = DMEM_RDATA >> {WB_ALU_RESULT[2:0], 3'b000};
    load_data = lane;
    case (funct3)
      3'b000:  load_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b010:  load_data = {{(XLEN-32){lane[31]}}, lane[31:0]};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, lane[15:0]};
      3'b110:  load_data = {{(XLEN-32){1'b0}}, lane[31:0]};
      default: load_data = lane;
    endcase
  end

  always_comb begin
    wen_op  = 1'b0;
    wr_data = WB_ALU_RESULT;
    case (opcode)
      7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011,
      7'b0110111, 7'b0010111: wen_op = 1'b1;
      7'b1101111, 7'b1100111: begin wen_op = 1'b1; wr_data = WB_NPC; end
      7'b0000011:             begin wen_op = 1'b1; wr_data = load_data; end
      7'b1110011:             begin wen_op = (funct3 != 3'b000); wr_data = WB_CSRFD; end
      default:                wen_op = 1'b0;
    endcase
  end

  // A timed-out load still leaves the latch but must not touch rd or INSTRET.
  assign wr_en = retire && wen_op && (rd != 5'd0) && !fault_now;

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[rd] = wr_data;
    regs_d[0] = '0;
  end

  always_comb begin
    DE_SR1_DATA = regs_q[DE_SR1_ID];
    DE_SR2_DATA = regs_q[DE_SR2_ID];
`ifdef WB_BYPASS_EN
    if (wr_en && (rd == DE_SR1_ID)) DE_SR1_DATA = wr_data;
    if (wr_en && (rd == DE_SR2_ID)) DE_SR2_DATA = wr_data;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (is_load && !DMEM_RVALID) begin
          state_d = LOAD_WAIT;
          cnt_d   = CW'(1);
        end
      end
      LOAD_WAIT: begin
        if (!is_load || DMEM_RVALID || at_timeout) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    redirect_v_d  = retire && WB_PC_MUX;
    redirect_pc_d = redirect_pc_q;
    if (retire && WB_PC_MUX) redirect_pc_d = {WB_ALU_RESULT[XLEN-1:1], 1'b0};
    load_fault_d  = fault_now;
    instret_d     = instret_q;
    if (retire && !fault_now) instret_d = instret_q + XLEN'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      redirect_v_q  <= 1'b0;
      redirect_pc_q <= '0;
      load_fault_q  <= 1'b0;
      instret_q     <= '0;
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redirect_v_q  <= redirect_v_d;
      redirect_pc_q <= redirect_pc_d;
      load_fault_q  <= load_fault_d;
      instret_q     <= instret_d;
      regs_q        <= regs_d;
    end
  end

  assign REDIRECT_V  = redirect_v_q;
  assign REDIRECT_PC = redirect_pc_q;
  assign LOAD_FAULT  = load_fault_q;
  assign INSTRET     = instret_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table, hand sequences and random instructions
// checked against a transaction-level register-file model.
module tb_writeback_stage;
  localparam int LTO = 16;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK = 1'b0, RESET;
  logic        WB_V, WB_PC_MUX, DMEM_RVALID;
  logic [31:0] WB_IR;
  logic [63:0] WB_NPC, WB_ALU_RESULT, WB_CSRFD, DMEM_RDATA;
  logic [4:0]  DE_SR1_ID, DE_SR2_ID;
  logic [63:0] DE_SR1_DATA, DE_SR2_DATA, REDIRECT_PC, INSTRET;
  logic        WB_STALL, REDIRECT_V, LOAD_FAULT;

  writeback_stage #(.XLEN(64), .LOAD_TIMEOUT(LTO)) dut (
    .CLK(CLK), .RESET(RESET), .WB_V(WB_V), .WB_IR(WB_IR), .WB_NPC(WB_NPC),
    .WB_ALU_RESULT(WB_ALU_RESULT), .WB_CSRFD(WB_CSRFD), .WB_PC_MUX(WB_PC_MUX),
    .DMEM_RVALID(DMEM_RVALID), .DMEM_RDATA(DMEM_RDATA),
    .DE_SR1_ID(DE_SR1_ID), .DE_SR2_ID(DE_SR2_ID),
    .DE_SR1_DATA(DE_SR1_DATA), .DE_SR2_DATA(DE_SR2_DATA), .WB_STALL(WB_STALL),
    .REDIRECT_V(REDIRECT_V), .REDIRECT_PC(REDIRECT_PC), .LOAD_FAULT(LOAD_FAULT),
    .INSTRET(INSTRET)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  logic [63:0] mregs [32];
  logic [63:0] minstret;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3);
    return {17'h0, f3, rd, op};
  endfunction

  function automatic bit writes_rd(input logic [31:0] ir);
    logic [6:0] op;
    op = ir[6:0];
    if (op == 7'h73) return ir[14:12] != 3'd0;
    return op inside {7'h33, 7'h13, 7'h3B, 7'h1B, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03};
  endfunction

  function automatic logic [63:0] load_value(input logic [2:0] f3, input logic [2:0] off, input logic [63:0] dw);
    logic [63:0] v, mask;
    int nbytes;
    bit sgn;
    nbytes = 1 << (f3 & 3'd3);
    sgn    = (f3 < 3'd4);
    v      = dw >> (8 * off);
    if (nbytes == 8) return v;
    mask = (64'd1 << (8 * nbytes)) - 64'd1;
    v    = v & mask;
    if (sgn && v[8*nbytes-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [63:0] result_of(input logic [31:0] ir, input logic [63:0] npc, alu, csr, rdata);
    case (ir[6:0])
      7'h6F, 7'h67: return npc;
      7'h73:        return csr;
      7'h03:        return load_value(ir[14:12], alu[2:0], rdata);
      default:      return alu;
    endcase
  endfunction

  function automatic logic [63:0] rf_read(input int id, input bit wen, input int rd, input logic [63:0] wd);
    if (BYP && wen && id == rd) return wd;
    return mregs[id];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    minstret = '0;
  endtask

  // Entered and left at a falling edge. Load data arrives in cycle k; any k beyond LTO+1 times out.
  task automatic run_instr(input logic v, input logic [31:0] ir, input logic [63:0] npc, alu, csr,
                           input logic pcmux, input int k, input logic [63:0] rdata,
                           input int s1, input int s2);
    bit is_ld, fin, flt, wen;
    int rd, id1, id2;
    logic [63:0] wd;
    is_ld = v && (ir[6:0] == 7'h03);
    rd    = int'(ir[11:7]);
    for (int c = 1; c <= LTO + 1; c++) begin
      WB_V = v; WB_IR = ir; WB_NPC = npc; WB_ALU_RESULT = alu; WB_CSRFD = csr; WB_PC_MUX = pcmux;
      DMEM_RVALID = is_ld && (c == k);
      DMEM_RDATA  = (c == k) ? rdata : {$urandom, $urandom};
      id1 = (s1 < 0) ? int'($urandom_range(0, 31)) : s1;
      id2 = (s2 < 0) ? int'($urandom_range(0, 31)) : s2;
      DE_SR1_ID = 5'(id1); DE_SR2_ID = 5'(id2);
      fin = !is_ld || (c == k) || (c == LTO + 1);
      flt = is_ld && fin && (c != k);
      wen = v && fin && !flt && writes_rd(ir) && rd != 0;
      wd  = result_of(ir, npc, alu, csr, rdata);
      #1;
      check("stall", {63'd0, WB_STALL}, {63'd0, !fin});
      check("sr1", DE_SR1_DATA, rf_read(id1, wen, rd, wd));
      check("sr2", DE_SR2_DATA, rf_read(id2, wen, rd, wd));
      @(posedge CLK); #1;
      if (wen) mregs[rd] = wd;
      if (v && fin && !flt) minstret = minstret + 64'd1;
      check("redirect_v", {63'd0, REDIRECT_V}, {63'd0, v && fin && pcmux});
      if (v && fin && pcmux) check("redirect_pc", REDIRECT_PC, {alu[63:1], 1'b0});
      check("load_fault", {63'd0, LOAD_FAULT}, {63'd0, flt});
      check("instret", INSTRET, minstret);
      @(negedge CLK);
      if (fin) break;
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic [63:0] npc, alu, csr, rdata;
    logic        pcmux;
    int          k;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t tbl[13];
  logic [6:0] ops[12] = '{7'h33, 7'h13, 7'h3B, 7'h1B, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h73, 7'h63, 7'h23};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{"addi_x5",  mk_ir(7'h13, 5'd5, 3'd0), 64'h0, 64'h1234, 64'h0, 64'h0, 1'b0, 1, 64'h1234};
    tbl[1]  = '{"addi_x0",  mk_ir(7'h13, 5'd0, 3'd0), 64'h0, 64'hFF, 64'h0, 64'h0, 1'b0, 1, 64'h0};
    tbl[2]  = '{"lb_off3",  mk_ir(7'h03, 5'd6, 3'd0), 64'h0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 1'b0, 3, 64'hFFFF_FFFF_FFFF_FF80};
    tbl[3]  = '{"lbu_off3", mk_ir(7'h03, 5'd7, 3'd4), 64'h0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 1'b0, 3, 64'h80};
    tbl[4]  = '{"jal_x1",   mk_ir(7'h6F, 5'd1, 3'd0), 64'h1004, 64'h2000, 64'h0, 64'h0, 1'b1, 1, 64'h1004};
    tbl[5]  = '{"ld_x8",    mk_ir(7'h03, 5'd8, 3'd3), 64'h0, 64'h2000, 64'h0, 64'h1122_3344_5566_7788, 1'b0, 1, 64'h1122_3344_5566_7788};
    tbl[6]  = '{"lh_off2",  mk_ir(7'h03, 5'd9, 3'd1), 64'h0, 64'h2002, 64'h0, 64'h0000_0000_8001_0000, 1'b0, 2, 64'hFFFF_FFFF_FFFF_8001};
    tbl[7]  = '{"lwu_off4", mk_ir(7'h03, 5'd10, 3'd6), 64'h0, 64'h2004, 64'h0, 64'hDEAD_BEEF_0000_0000, 1'b0, 1, 64'h0000_0000_DEAD_BEEF};
    tbl[8]  = '{"lw_off4",  mk_ir(7'h03, 5'd11, 3'd2), 64'h0, 64'h2004, 64'h0, 64'hDEAD_BEEF_0000_0000, 1'b0, 1, 64'hFFFF_FFFF_DEAD_BEEF};
    tbl[9]  = '{"csrrw",    mk_ir(7'h73, 5'd12, 3'd1), 64'h0, 64'h99, 64'h55, 64'h0, 1'b0, 1, 64'h55};
    tbl[10] = '{"jalr_x13", mk_ir(7'h67, 5'd13, 3'd0), 64'h3008, 64'h4001, 64'h0, 64'h0, 1'b1, 1, 64'h3008};
    tbl[11] = '{"store",    mk_ir(7'h23, 5'd5, 3'd3), 64'h0, 64'h777, 64'h0, 64'h0, 1'b0, 1, 64'h1234};
    tbl[12] = '{"lui_x14",  mk_ir(7'h37, 5'd14, 3'd0), 64'h0, 64'hABC000, 64'h0, 64'h0, 1'b0, 1, 64'hABC000};

    RESET = 1'b1; WB_V = 1'b0; WB_IR = '0; WB_NPC = '0; WB_ALU_RESULT = '0; WB_CSRFD = '0;
    WB_PC_MUX = 1'b0; DMEM_RVALID = 1'b0; DMEM_RDATA = '0; DE_SR1_ID = 5'd5; DE_SR2_ID = 5'd31;
    model_reset();
    @(posedge CLK); @(posedge CLK); #1;
    check("reset_instret", INSTRET, 64'h0);
    check("reset_redirect_v", {63'd0, REDIRECT_V}, 64'h0);
    check("reset_redirect_pc", REDIRECT_PC, 64'h0);
    check("reset_load_fault", {63'd0, LOAD_FAULT}, 64'h0);
    check("reset_x5", DE_SR1_DATA, 64'h0);
    check("reset_x31", DE_SR2_DATA, 64'h0);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_instr(1'b1, tbl[i].ir, tbl[i].npc, tbl[i].alu, tbl[i].csr, tbl[i].pcmux, tbl[i].k, tbl[i].rdata, -1, -1);
      WB_V = 1'b0; DE_SR1_ID = tbl[i].ir[11:7];
      #1;
      check(tbl[i].name, DE_SR1_DATA, tbl[i].exp_rd);
    end

    // Load timeout: no response ever arrives, x6 must keep its value.
    run_instr(1'b1, mk_ir(7'h03, 5'd6, 3'd3), 64'h0, 64'h5000, 64'h0, 1'b0, 99, 64'h0, -1, -1);
    run_instr(1'b0, '0, '0, '0, '0, 1'b0, 1, '0, 6, 0);
    check("timeout_x6", DE_SR1_DATA, 64'hFFFF_FFFF_FFFF_FF80);

    // Same-cycle write/read of x7.
    run_instr(1'b1, mk_ir(7'h13, 5'd7, 3'd0), 64'h0, 64'hABCD, 64'h0, 1'b0, 1, 64'h0, 7, 7);
    // Bubble carrying load opcode and PC_MUX must be inert.
    run_instr(1'b0, mk_ir(7'h03, 5'd7, 3'd0), 64'h0, 64'h8000, 64'h0, 1'b1, 1, 64'h0, 7, 0);
    check("post_bypass_x7", DE_SR1_DATA, 64'hABCD);

    // Reset in the middle of a load wait.
    WB_V = 1'b1; WB_IR = mk_ir(7'h03, 5'd3, 3'd3); WB_ALU_RESULT = 64'h6000; DMEM_RVALID = 1'b0; WB_PC_MUX = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
    model_reset();
    check("rst_wait_instret", INSTRET, 64'h0);
    check("rst_wait_redirect", {63'd0, REDIRECT_V}, 64'h0);
    @(negedge CLK);
    RESET = 1'b0; WB_V = 1'b0;
    run_instr(1'b0, '0, '0, '0, '0, 1'b0, 1, '0, 5, 1);
    run_instr(1'b1, mk_ir(7'h03, 5'd3, 3'd3), 64'h0, 64'h6000, 64'h0, 1'b0, 99, 64'h0, -1, -1);

    for (int n = 0; n < 400; n++) begin
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        v, pm;
      int          k;
      op = ops[$urandom_range(0, 11)];
      f3 = 3'($urandom_range(0, 7));
      if (op == 7'h03) f3 = 3'($urandom_range(0, 6));
      v  = ($urandom_range(0, 7) != 0);
      pm = (op inside {7'h6F, 7'h67, 7'h63}) ? 1'($urandom_range(0, 1)) : 1'b0;
      k  = (op == 7'h03) ? int'($urandom_range(1, 20)) : 1;
      run_instr(v, mk_ir(op, 5'($urandom_range(0, 31)), f3), {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, pm, k, {$urandom, $urandom}, -1, -1);
    end

    for (int r = 0; r < 32; r++) begin
      WB_V = 1'b0; DE_SR1_ID = 5'(r); DE_SR2_ID = 5'(31 - r);
      #1;
      check("final_sr1", DE_SR1_DATA, mregs[r]);
      check("final_sr2", DE_SR2_DATA, mregs[31 - r]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
